// File: rtl/instr_decode_queue.sv
// -----------------------------------------------------------------------------
// instr_decode_queue
//
// Buffered decode stage between instruction fetch and execute. Raw
// instructions are accepted over a valid/ready handshake and decoded into a
// datapath control word as they are written. Up to DEPTH decoded entries are
// held in a circular FIFO. A per-register scoreboard for the integer and xmm
// register files holds the head entry back on RAW/WAW hazards until the
// producing register write retires.
//
// Optional feature macro: DECODE_XMM_EN
//   defined   : FP load/store (opcodes 0x01/0x09) decode, xmm scoreboard active
//   undefined : FP load/store decode as illegal, xmm scoreboard absent,
//               retire_is_xmm ignored (retire always clears an integer bit)
//
// Parameters
//   DEPTH  FIFO entries, power of two, >= 2
//   CNT_W  width of count
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready             fetch handshake
//   in_instr, in_pc               instruction word and its PC
//   out_valid/out_ready           issue handshake
//   out_instr, out_pc             head entry
//   should_read_mem/_write_mem/_write_reg/_write_xmm   head enables
//   rs1_addr, rs2_addr, rd_addr   head register fields
//   alu_a_src, alu_b_src          ALU operand selects
//   reg_write_src, xmm_write_src, mem_write_src       writeback/store selects
//   out_illegal                   head is unsupported or malformed
//   retire_valid, retire_rd, retire_is_xmm            register write committed
//   flush                         discard all queued entries
//   count                         occupied entries
// -----------------------------------------------------------------------------
module instr_decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic             should_read_mem,
    output logic             should_write_mem,
    output logic             should_write_reg,
    output logic             should_write_xmm,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic [2:0]       alu_a_src,
    output logic [2:0]       alu_b_src,
    output logic [2:0]       reg_write_src,
    output logic [2:0]       xmm_write_src,
    output logic [1:0]       mem_write_src,
    output logic             out_illegal,
    input  logic             retire_valid,
    input  logic [4:0]       retire_rd,
    input  logic             retire_is_xmm,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // ALU operand selects
    localparam logic [2:0] SRC_ZERO     = 3'd0;
    localparam logic [2:0] SRC_PC_PLUS4 = 3'd1;
    localparam logic [2:0] SRC_PC       = 3'd2;
    localparam logic [2:0] SRC_REG      = 3'd3;
    localparam logic [2:0] SRC_IMM12    = 3'd4;
    localparam logic [2:0] SRC_IMM20    = 3'd5;

    // Writeback / store data selects
    localparam logic [2:0] WB_ALU  = 3'd2;
    localparam logic [2:0] WB_MEM  = 3'd4;
    localparam logic [1:0] MEM_REG = 2'd1;
    localparam logic [1:0] MEM_XMM = 2'd2;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OP_LOAD     = 5'h00;
    localparam logic [4:0] OP_LOAD_FP  = 5'h01;
    localparam logic [4:0] OP_FENCE    = 5'h03;
    localparam logic [4:0] OP_IMM      = 5'h04;
    localparam logic [4:0] OP_AUIPC    = 5'h05;
    localparam logic [4:0] OP_STORE    = 5'h08;
    localparam logic [4:0] OP_STORE_FP = 5'h09;
    localparam logic [4:0] OP_OP       = 5'h0c;
    localparam logic [4:0] OP_LUI      = 5'h0d;
    localparam logic [4:0] OP_BRANCH   = 5'h18;
    localparam logic [4:0] OP_JALR     = 5'h19;
    localparam logic [4:0] OP_JAL      = 5'h1b;

    // Decoded control word kept alongside each queued instruction. The
    // use_* flags tell the hazard check which scoreboard bits the entry reads.
    typedef struct packed {
        logic       illegal;
        logic       read_mem;
        logic       write_mem;
        logic       write_reg;
        logic       write_xmm;
        logic [2:0] a_src;
        logic [2:0] b_src;
        logic [2:0] reg_src;
        logic [2:0] xmm_src;
        logic [1:0] mem_src;
        logic       use_rs1;
        logic       use_rs2_int;
        logic       use_rs2_xmm;
    } dec_t;

    // Only the low seven bits select the control word; the register fields
    // are taken from the stored instruction at the head.
    function automatic dec_t decode(input logic [6:0] op7);
        dec_t d;
        d = '0;
        if (op7[1:0] == 2'b11) begin
            case (op7[6:2])
                OP_LOAD: begin
                    d.read_mem  = 1'b1;
                    d.write_reg = 1'b1;
                    d.a_src     = SRC_REG;
                    d.b_src     = SRC_IMM12;
                    d.reg_src   = WB_MEM;
                    d.use_rs1   = 1'b1;
                end
`ifdef DECODE_XMM_EN
                OP_LOAD_FP: begin
                    d.read_mem  = 1'b1;
                    d.write_xmm = 1'b1;
                    d.a_src     = SRC_REG;
                    d.b_src     = SRC_IMM12;
                    d.xmm_src   = WB_MEM;
                    d.use_rs1   = 1'b1;
                end
                OP_STORE_FP: begin
                    d.write_mem   = 1'b1;
                    d.a_src       = SRC_REG;
                    d.b_src       = SRC_IMM12;
                    d.mem_src     = MEM_XMM;
                    d.use_rs1     = 1'b1;
                    d.use_rs2_xmm = 1'b1;
                end
`else
                OP_LOAD_FP, OP_STORE_FP: begin
                    d.illegal = 1'b1;
                end
`endif
                OP_FENCE: begin
                    d.illegal = 1'b0;
                end
                OP_IMM: begin
                    d.write_reg = 1'b1;
                    d.a_src     = SRC_REG;
                    d.b_src     = SRC_IMM12;
                    d.reg_src   = WB_ALU;
                    d.use_rs1   = 1'b1;
                end
                OP_AUIPC: begin
                    d.write_reg = 1'b1;
                    d.a_src     = SRC_PC;
                    d.b_src     = SRC_IMM20;
                    d.reg_src   = WB_ALU;
                end
                OP_STORE: begin
                    d.write_mem   = 1'b1;
                    d.a_src       = SRC_REG;
                    d.b_src       = SRC_IMM12;
                    d.mem_src     = MEM_REG;
                    d.use_rs1     = 1'b1;
                    d.use_rs2_int = 1'b1;
                end
                OP_OP: begin
                    d.write_reg   = 1'b1;
                    d.a_src       = SRC_REG;
                    d.b_src       = SRC_REG;
                    d.reg_src     = WB_ALU;
                    d.use_rs1     = 1'b1;
                    d.use_rs2_int = 1'b1;
                end
                OP_LUI: begin
                    d.write_reg = 1'b1;
                    d.a_src     = SRC_ZERO;
                    d.b_src     = SRC_IMM20;
                    d.reg_src   = WB_ALU;
                end
                OP_BRANCH: begin
                    d.a_src       = SRC_REG;
                    d.b_src       = SRC_REG;
                    d.use_rs1     = 1'b1;
                    d.use_rs2_int = 1'b1;
                end
                OP_JALR: begin
                    d.write_reg = 1'b1;
                    d.a_src     = SRC_PC_PLUS4;
                    d.b_src     = SRC_ZERO;
                    d.reg_src   = WB_ALU;
                    d.use_rs1   = 1'b1;
                end
                OP_JAL: begin
                    d.write_reg = 1'b1;
                    d.a_src     = SRC_PC_PLUS4;
                    d.b_src     = SRC_ZERO;
                    d.reg_src   = WB_ALU;
                end
                default: begin
                    d.illegal = 1'b1;
                end
            endcase
        end else begin
            // Compressed / malformed encodings: flagged, everything else zero.
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    // FIFO storage and state
    logic [31:0]      instr_mem_r [DEPTH];
    logic [31:0]      pc_mem_r    [DEPTH];
    dec_t             dec_mem_r   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Scoreboards: one pending-write bit per architectural register
    logic [31:0] int_sb_r;
    logic [31:0] int_sb_next_s;
    logic [31:0] int_set_s;
    logic [31:0] int_clr_s;
    logic [31:0] xmm_sb_s;
`ifdef DECODE_XMM_EN
    logic [31:0] xmm_sb_r;
    logic [31:0] xmm_sb_next_s;
    logic [31:0] xmm_set_s;
    logic [31:0] xmm_clr_s;
`else
    logic        unused_retire_is_xmm_s;
`endif

    // Head view and handshake
    logic        nonempty_s;
    dec_t        head_dec_s;
    logic [31:0] head_instr_s;
    logic [31:0] head_pc_s;
    logic [4:0]  head_rs1_s;
    logic [4:0]  head_rs2_s;
    logic [4:0]  head_rd_s;
    logic        blocked_s;
    logic        in_ready_s;
    logic        out_valid_s;
    logic        enq_s;
    logic        deq_s;

    assign xmm_sb_s = '0;

    // Head entry selection; an empty queue presents all-zero fields.
    always_comb begin
        nonempty_s = (count_r != '0);
        if (nonempty_s) begin
            head_dec_s   = dec_mem_r[rd_ptr_r];
            head_instr_s = instr_mem_r[rd_ptr_r];
            head_pc_s    = pc_mem_r[rd_ptr_r];
        end else begin
            head_dec_s   = '0;
            head_instr_s = 32'h0000_0000;
            head_pc_s    = 32'h0000_0000;
        end
        head_rs1_s = head_instr_s[19:15];
        head_rs2_s = head_instr_s[24:20];
        head_rd_s  = head_instr_s[11:7];
    end

    // Hazard check against the registered scoreboards (no retire bypass).
    always_comb begin
        blocked_s = 1'b0;
        if (!head_dec_s.illegal) begin
            blocked_s = (head_dec_s.use_rs1     && int_sb_r[head_rs1_s])
                     || (head_dec_s.use_rs2_int && int_sb_r[head_rs2_s])
                     || (head_dec_s.write_reg   && int_sb_r[head_rd_s])
`ifdef DECODE_XMM_EN
                     || (head_dec_s.use_rs2_xmm && xmm_sb_r[head_rs2_s])
                     || (head_dec_s.write_xmm   && xmm_sb_r[head_rd_s])
`endif
                     || (head_dec_s.use_rs2_xmm && xmm_sb_s[head_rs2_s]);
        end else begin
            blocked_s = 1'b0;
        end
    end

    // Handshakes. in_ready depends only on occupancy, so a full queue
    // refuses input even when the head leaves in the same cycle.
    always_comb begin
        in_ready_s  = rst_n && (count_r < DEPTH_C);
        out_valid_s = rst_n && !flush && nonempty_s && !blocked_s;
        enq_s       = in_valid && in_ready_s && !flush;
        deq_s       = out_valid_s && out_ready;
    end

    // Scoreboard set-on-issue / clear-on-retire; integer x0 never tracked.
    always_comb begin
        int_set_s = 32'h0000_0000;
        int_clr_s = 32'h0000_0000;
        if (deq_s && head_dec_s.write_reg && (head_rd_s != 5'd0)) begin
            int_set_s = 32'h0000_0001 << head_rd_s;
        end else begin
            int_set_s = 32'h0000_0000;
        end
`ifdef DECODE_XMM_EN
        if (retire_valid && !retire_is_xmm) begin
`else
        if (retire_valid) begin
`endif
            int_clr_s = 32'h0000_0001 << retire_rd;
        end else begin
            int_clr_s = 32'h0000_0000;
        end
        int_sb_next_s = ((int_sb_r & ~int_clr_s) | int_set_s) & 32'hFFFF_FFFE;
    end

`ifdef DECODE_XMM_EN
    // xmm scoreboard next state.
    always_comb begin
        xmm_set_s = 32'h0000_0000;
        xmm_clr_s = 32'h0000_0000;
        if (deq_s && head_dec_s.write_xmm) begin
            xmm_set_s = 32'h0000_0001 << head_rd_s;
        end else begin
            xmm_set_s = 32'h0000_0000;
        end
        if (retire_valid && retire_is_xmm) begin
            xmm_clr_s = 32'h0000_0001 << retire_rd;
        end else begin
            xmm_clr_s = 32'h0000_0000;
        end
        xmm_sb_next_s = (xmm_sb_r & ~xmm_clr_s) | xmm_set_s;
    end

    // xmm scoreboard register; flush leaves it intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xmm_sb_r <= 32'h0000_0000;
        end else begin
            xmm_sb_r <= xmm_sb_next_s;
        end
    end
`else
    assign unused_retire_is_xmm_s = retire_is_xmm;
`endif

    // Integer scoreboard register; flush leaves it intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_sb_r <= 32'h0000_0000;
        end else begin
            int_sb_r <= int_sb_next_s;
        end
    end

    // Pointer and occupancy update; flush overrides any transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage: decode happens once, on the way in.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            instr_mem_r[wr_ptr_r] <= in_instr;
            pc_mem_r[wr_ptr_r]    <= in_pc;
            dec_mem_r[wr_ptr_r]   <= decode(in_instr[6:0]);
        end
    end

    // Output drive from the head entry.
    always_comb begin
        in_ready         = in_ready_s;
        out_valid        = out_valid_s;
        out_instr        = head_instr_s;
        out_pc           = head_pc_s;
        should_read_mem  = head_dec_s.read_mem;
        should_write_mem = head_dec_s.write_mem;
        should_write_reg = head_dec_s.write_reg;
        should_write_xmm = head_dec_s.write_xmm;
        rs1_addr         = head_rs1_s;
        rs2_addr         = head_rs2_s;
        rd_addr          = head_rd_s;
        alu_a_src        = head_dec_s.a_src;
        alu_b_src        = head_dec_s.b_src;
        reg_write_src    = head_dec_s.reg_src;
        xmm_write_src    = head_dec_s.xmm_src;
        mem_write_src    = head_dec_s.mem_src;
        out_illegal      = head_dec_s.illegal;
        count            = count_r;
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_queue
//
// Directed bench for instr_decode_queue: a table of single-instruction decode
// vectors with hand-computed control words, followed by hand-written
// sequences for reset, RAW blocking, full queue, flush, mid-run reset and
// (when DECODE_XMM_EN is defined) the xmm scoreboard.
// -----------------------------------------------------------------------------
module tb_instr_decode_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [31:0]      out_pc;
    logic             should_read_mem;
    logic             should_write_mem;
    logic             should_write_reg;
    logic             should_write_xmm;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [4:0]       rd_addr;
    logic [2:0]       alu_a_src;
    logic [2:0]       alu_b_src;
    logic [2:0]       reg_write_src;
    logic [2:0]       xmm_write_src;
    logic [1:0]       mem_write_src;
    logic             out_illegal;
    logic             retire_valid;
    logic [4:0]       retire_rd;
    logic             retire_is_xmm;
    logic             flush;
    logic [CNT_W-1:0] count;

    instr_decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .in_pc            (in_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .should_read_mem  (should_read_mem),
        .should_write_mem (should_write_mem),
        .should_write_reg (should_write_reg),
        .should_write_xmm (should_write_xmm),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rd_addr          (rd_addr),
        .alu_a_src        (alu_a_src),
        .alu_b_src        (alu_b_src),
        .reg_write_src    (reg_write_src),
        .xmm_write_src    (xmm_write_src),
        .mem_write_src    (mem_write_src),
        .out_illegal      (out_illegal),
        .retire_valid     (retire_valid),
        .retire_rd        (retire_rd),
        .retire_is_xmm    (retire_is_xmm),
        .flush            (flush),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093;
    localparam logic [31:0] I_ADD_X2  = 32'h0010_8133;
    localparam logic [31:0] I_FENCE   = 32'h0FF0_000F;
    localparam logic [31:0] I_FLW_F3  = 32'h0001_2187;
    localparam logic [31:0] I_FSW_F3  = 32'h0031_2027;

    // exp layout: {ill, rd_mem, wr_mem, wr_reg, wr_xmm, a[3], b[3],
    //              reg_src[3], xmm_src[3], mem_src[2], rd[5]}
    typedef struct {
        logic [31:0] instr;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [15];
    int   n_vec;
    int   n_miss;

    function automatic logic [23:0] mk(input logic ill, input logic rm, input logic wm,
                                       input logic wr, input logic wx,
                                       input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] rs, input logic [2:0] xs,
                                       input logic [1:0] ms, input logic [4:0] rd);
        return {ill, rm, wm, wr, wx, a, b, rs, xs, ms, rd};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        in_instr = ins;
        in_pc    = pc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic retire(input logic [4:0] rd, input logic is_xmm);
        retire_valid  = 1'b1;
        retire_rd     = rd;
        retire_is_xmm = is_xmm;
        tick();
        retire_valid  = 1'b0;
    endtask

    logic [23:0] act_w;

    initial begin
        n_vec  = 0;
        n_miss = 0;

        vecs[0]  = '{I_ADDI_X1,     mk(1'b0,1'b0,1'b0,1'b1,1'b0,3'd3,3'd4,3'd2,3'd0,2'd0,5'd1)};
        vecs[1]  = '{32'h0081_2283, mk(1'b0,1'b1,1'b0,1'b1,1'b0,3'd3,3'd4,3'd4,3'd0,2'd0,5'd5)};
        vecs[2]  = '{32'h0063_A223, mk(1'b0,1'b0,1'b1,1'b0,1'b0,3'd3,3'd4,3'd0,3'd0,2'd1,5'd4)};
        vecs[3]  = '{32'h0052_01B3, mk(1'b0,1'b0,1'b0,1'b1,1'b0,3'd3,3'd3,3'd2,3'd0,2'd0,5'd3)};
        vecs[4]  = '{32'h1234_5537, mk(1'b0,1'b0,1'b0,1'b1,1'b0,3'd0,3'd5,3'd2,3'd0,2'd0,5'd10)};
        vecs[5]  = '{32'h0000_1397, mk(1'b0,1'b0,1'b0,1'b1,1'b0,3'd2,3'd5,3'd2,3'd0,2'd0,5'd7)};
        vecs[6]  = '{32'h0000_00EF, mk(1'b0,1'b0,1'b0,1'b1,1'b0,3'd1,3'd0,3'd2,3'd0,2'd0,5'd1)};
        vecs[7]  = '{32'h0000_8067, mk(1'b0,1'b0,1'b0,1'b1,1'b0,3'd1,3'd0,3'd2,3'd0,2'd0,5'd0)};
        vecs[8]  = '{32'h0020_8463, mk(1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,3'd3,3'd0,3'd0,2'd0,5'd8)};
        vecs[9]  = '{I_FENCE,       mk(1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,3'd0,3'd0,2'd0,5'd0)};
        vecs[10] = '{32'h0000_0000, mk(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,3'd0,3'd0,2'd0,5'd0)};
        vecs[11] = '{32'hFFFF_FFFF, mk(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,3'd0,3'd0,2'd0,5'd31)};
`ifdef DECODE_XMM_EN
        vecs[12] = '{I_FLW_F3,      mk(1'b0,1'b1,1'b0,1'b0,1'b1,3'd3,3'd4,3'd0,3'd4,2'd0,5'd3)};
        vecs[13] = '{I_FSW_F3,      mk(1'b0,1'b0,1'b1,1'b0,1'b0,3'd3,3'd4,3'd0,3'd0,2'd2,5'd0)};
`else
        vecs[12] = '{I_FLW_F3,      mk(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,3'd0,3'd0,2'd0,5'd3)};
        vecs[13] = '{I_FSW_F3,      mk(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,3'd0,3'd0,2'd0,5'd0)};
`endif
        vecs[14] = '{32'h0050_0091, mk(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,3'd0,3'd0,2'd0,5'd1)};

        // ---- reset, with fetch already offering an instruction ----
        rst_n = 1'b0; in_valid = 1'b1; in_instr = I_FENCE; in_pc = 32'h0;
        out_ready = 1'b0; retire_valid = 1'b0; retire_rd = 5'd0;
        retire_is_xmm = 1'b0; flush = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        tick();
        tick();
        chk("rst_in_ready_hold", 64'(in_ready), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("empty_out_instr", 64'(out_instr), 64'd0);
        chk("empty_wr_reg", 64'(should_write_reg), 64'd0);

        // ---- decode table ----
        for (int i = 0; i < 15; i++) begin
            chk("vec_pre_empty", 64'(out_valid), 64'd0);
            push(vecs[i].instr, 32'h1000 + 32'(i * 4));
            act_w = {out_illegal, should_read_mem, should_write_mem, should_write_reg,
                     should_write_xmm, alu_a_src, alu_b_src, reg_write_src,
                     xmm_write_src, mem_write_src, rd_addr};
            chk("vec_out_valid", 64'(out_valid), 64'd1);
            chk("vec_count", 64'(count), 64'd1);
            chk("vec_ctrl", 64'(act_w), 64'(vecs[i].exp));
            chk("vec_instr", 64'(out_instr), 64'(vecs[i].instr));
            chk("vec_pc", 64'(out_pc), 64'(32'h1000 + 32'(i * 4)));
            pop();
            chk("vec_drained", 64'(count), 64'd0);
            retire(vecs[i].exp[4:0], vecs[i].exp[19]);
        end

        // ---- register fields of addi x1,x0,5 ----
        push(I_ADDI_X1, 32'h0);
        chk("addi_rs1", 64'(rs1_addr), 64'd0);
        chk("addi_rs2", 64'(rs2_addr), 64'd5);

        // ---- RAW: add x2,x1,x1 waits for x1 to retire ----
        pop();
        push(I_ADD_X2, 32'h4);
        chk("raw_blocked", 64'(out_valid), 64'd0);
        chk("raw_count", 64'(count), 64'd1);
        tick();
        chk("raw_still_blocked", 64'(out_valid), 64'd0);
        retire_valid = 1'b1; retire_rd = 5'd1; retire_is_xmm = 1'b0;
        #1;
        chk("raw_no_bypass", 64'(out_valid), 64'd0);
        tick();
        retire_valid = 1'b0;
        chk("raw_release", 64'(out_valid), 64'd1);
        pop();
        retire(5'd2, 1'b0);

        // ---- full queue: 5th push refused even with a dequeue ----
        for (int k = 0; k < 4; k++) begin
            push(I_FENCE, 32'h2000 + 32'(k * 4));
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_instr = I_FENCE; in_pc = 32'h2010; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("full_deq_in_ready", 64'(in_ready), 64'd0);
        chk("full_head_pc", 64'(out_pc), 64'h2000);
        tick();
        in_valid = 1'b0;
        chk("full_deq_only", 64'(count), 64'd3);
        for (int k = 1; k < 4; k++) begin
            chk("full_order", 64'(out_pc), 64'(32'h2000 + 32'(k * 4)));
            tick();
        end
        out_ready = 1'b0;
        chk("full_drained", 64'(count), 64'd0);
        chk("full_drained_ov", 64'(out_valid), 64'd0);

        // ---- simultaneous enqueue and dequeue ----
        push(I_FENCE, 32'h3000);
        in_instr = I_FENCE; in_pc = 32'h3004; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("simul_count", 64'(count), 64'd1);
        chk("simul_head", 64'(out_pc), 64'h3004);
        pop();

        // ---- flush keeps scoreboard ----
        push(I_ADDI_X1, 32'h4000);
        pop();
        for (int k = 0; k < 3; k++) begin
            push(I_FENCE, 32'h4004 + 32'(k * 4));
        end
        chk("flush_pre_count", 64'(count), 64'd3);
        flush = 1'b1; in_valid = 1'b1; in_instr = I_FENCE; out_ready = 1'b1;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        push(I_ADD_X2, 32'h4100);
        chk("flush_sb_kept", 64'(out_valid), 64'd0);
        retire(5'd1, 1'b0);
        chk("flush_release", 64'(out_valid), 64'd1);
        pop();
        retire(5'd2, 1'b0);

        // ---- mid-operation reset clears entries and hazards ----
        push(I_ADDI_X1, 32'h5000);
        pop();
        push(I_FENCE, 32'h5004);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        push(I_ADD_X2, 32'h5100);
        chk("mid_rst_sb_clear", 64'(out_valid), 64'd1);
        pop();
        retire(5'd2, 1'b0);

`ifdef DECODE_XMM_EN
        // ---- xmm RAW: fsw reading xs3 waits for an xmm retire of 3 ----
        push(I_FLW_F3, 32'h6000);
        in_instr = I_FSW_F3; in_pc = 32'h6004; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("xmm_count", 64'(count), 64'd1);
        chk("xmm_blocked", 64'(out_valid), 64'd0);
        retire(5'd3, 1'b0);
        chk("xmm_int_retire", 64'(out_valid), 64'd0);
        retire(5'd3, 1'b1);
        chk("xmm_release", 64'(out_valid), 64'd1);
        pop();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
# instr_decode_queue

Buffered decode stage between instruction fetch and execute in the RISC-V core with the xmm (FP) register file. Accepts raw instructions over a valid/ready handshake, decodes the datapath control word at enqueue, and holds up to DEPTH decoded entries in a FIFO. A per-register scoreboard for the integer and xmm files holds back the head entry on RAW/WAW hazards until the producing write retires.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- CNT_W, $clog2(DEPTH)+1, width of `count`
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid` / `in_ready`  in / out  1  fetch handshake
- `in_instr`, `in_pc`  in  32 each  instruction word and its PC
- `out_valid` / `out_ready`  out / in  1  issue handshake
- `out_instr`, `out_pc`  out  32 each  head entry
- `should_read_mem`, `should_write_mem`, `should_write_reg`, `should_write_xmm`  out  1 each  enables
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  5 each  instr[19:15], [24:20], [11:7]
- `alu_a_src`, `alu_b_src`  out  3 each  ZERO=0, PC_PLUS4=1, PC=2, REG=3, IMM12=4, IMM20=5
- `reg_write_src`  out  3  ALU=2, MEM=4; `xmm_write_src`  out  3  MEM=4; `mem_write_src`  out  2  REG=1, XMM=2
- `out_illegal`  out  1  head is unsupported/malformed
- `retire_valid`  in  1  a register write has committed
- `retire_rd`  in  5; `retire_is_xmm`  in  1  selects file to clear
- `flush`  in  1  discard all queued entries
- `count`  out  CNT_W  occupied entries

## Operation
- Decode on instr[6:2]; instr[1:0] != 2'b11 -> illegal. Fields not listed are driven 0 (no X).
- 0x00 load: read_mem, write_reg, a=REG, b=IMM12, reg_src=MEM. 0x01 FP load: read_mem, write_xmm, a=REG, b=IMM12, xmm_src=MEM.
- 0x03 fence: all enables 0, legal. 0x04 op-imm: write_reg, a=REG, b=IMM12, reg_src=ALU. 0x05 auipc: write_reg, a=PC, b=IMM20, ALU.
- 0x08 store: write_mem, a=REG, b=IMM12, mem_src=REG. 0x09 FP store: same, mem_src=XMM.
- 0x0c op: write_reg, a=REG, b=REG, ALU. 0x0d lui: write_reg, a=ZERO, b=IMM20, ALU. 0x18 branch: a=REG, b=REG, no writes.
- 0x19 jalr, 0x1b jal: write_reg, a=PC_PLUS4, b=ZERO, ALU. Any other opcode: illegal, enables 0.
- Scoreboard: 32 integer bits + 32 xmm bits. Integer bit 0 is never set.
- Head sources: rs1 (int) for 0x00/0x01/0x04/0x08/0x09/0x0c/0x18/0x19; rs2 (int) for 0x08/0x0c/0x18; rs2 (xmm) for 0x09. Destination: rd in file selected by write_reg/write_xmm.
- Head blocked while any used source bit or destination bit is set. Illegal heads never block.
- On issue (out_valid & out_ready): set destination bit (int if write_reg & rd!=0; xmm if write_xmm). On `retire_valid`: clear the selected bit. No bypass: blocked head is released the cycle after the retire edge.
- `out_*` fields are combinational from the head entry; stable while out_valid & !out_ready.

## Timing
- Reset (rst_n=0 at edge): pointers 0, count 0, scoreboard 0; out_valid=0, in_ready=0 during reset, 1 the cycle after. Mid-operation reset discards all entries and hazards.
- Latency: accepted at edge N -> out_valid earliest in cycle N+1 (no enqueue->issue bypass).
- in_ready = (count < DEPTH); when full, in_ready stays 0 even if a dequeue occurs that cycle.
- Simultaneous enqueue and dequeue: count unchanged; pointers wrap modulo DEPTH.
- Empty: out_valid=0, out_* fields 0.
- flush: at the edge, count and pointers reset; any enqueue/dequeue that cycle is ignored; scoreboard is preserved (in-flight writes still retire). out_valid=0 during the flush cycle.
- retire and issue in the same cycle are both applied; they cannot target the same bit (WAW block).

## Configuration
- `DECODE_XMM_EN` defined: FP load/store decode as above; xmm scoreboard present.
- Undefined: 0x01 and 0x09 decode as illegal; should_write_xmm, xmm_write_src, mem_write_src=XMM are never asserted; xmm scoreboard and `retire_is_xmm` are ignored (retire always clears an integer bit).

## Test plan
- Reset then push `addi x1,x0,5` (0x00500093) -> out_valid at N+1, write_reg=1, a=3, b=4, reg_src=2, rd=1.
- Issue `addi x1`, then push `add x2,x1,x1` -> blocked; retire_rd=1 -> issues the following cycle.
- DEPTH=4, out_ready=0, push 5 instructions -> in_ready=0 after 4th, count=4; one dequeue+enqueue in the same full cycle -> enqueue not accepted.
- Push 0x00000000 and 0xFFFFFFFF -> out_illegal=1, all enables 0, dequeued without blocking.
- With `DECODE_XMM_EN`: FP load to x3 (xmm) then FP store reading xs3 -> store blocked until retire_is_xmm=1, retire_rd=3; without macro both flagged illegal.
- 3 entries queued, assert flush with in_valid=1 -> count=0 next cycle, scoreboard bits set before the flush still set.
